// File: rtl/race_launcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | race_launcher                                                              |
// | Arbiter-PUF race sequencer: majority-voted responses per challenge.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module race_launcher #(
  parameter int CHAL_W   = 64,
  parameter int NUM_RESP = 8,
  parameter int VOTES    = 5,
  parameter int SETTLE   = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CHAL_W-1:0]   challenge,
  output logic [CHAL_W-1:0]   chal_out,
  output logic                launch,
  output logic                arb_rst,
  input  logic                arb_done,
  input  logic                arb_result,
  output logic                busy,
  output logic                resp_valid,
  output logic [NUM_RESP-1:0] response,
  output logic                timeout_err
);

  localparam int c_vote_w = $clog2(VOTES + 1);
  localparam int c_idx_w  = $clog2(NUM_RESP + 1);
  localparam int c_wait_w = $clog2(TIMEOUT + 1);
  localparam int c_set_w  = $clog2(SETTLE + 1);

  localparam logic [c_vote_w-1:0] c_votes       = c_vote_w'(VOTES);
  localparam logic [c_vote_w-1:0] c_half        = c_vote_w'(VOTES / 2);
  localparam logic [c_idx_w-1:0]  c_last_idx    = c_idx_w'(NUM_RESP - 1);
  localparam logic [c_wait_w-1:0] c_timeout     = c_wait_w'(TIMEOUT);
  localparam logic [c_set_w-1:0]  c_settle_last = c_set_w'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_FIRE  = 3'd2,
    S_WAIT  = 3'd3,
    S_EVAL  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_launch_nx;
  logic                w_bit_done;
  logic                w_maj;
  logic                r_launch;
  logic                r_arb_rst;
  logic                r_done_s1, r_done_s2;
  logic                r_res_s1, r_res_s2;
  logic [CHAL_W-1:0]   r_chal;
  logic [c_idx_w-1:0]  r_idx;
  logic [c_vote_w-1:0] r_votes;
  logic [c_vote_w-1:0] r_ones;
  logic [c_wait_w-1:0] r_wait;
  logic [c_set_w-1:0]  r_set;
  logic [NUM_RESP-1:0] r_resp;
  logic                r_to;

  assign w_bit_done  = (r_votes >= c_votes);
  assign w_maj       = (r_ones > c_half);

  assign chal_out    = r_chal;
  assign launch      = r_launch;
  assign arb_rst     = r_arb_rst;
  assign busy        = (r_state != S_IDLE);
  assign resp_valid  = (r_state == S_DONE);
  assign response    = r_resp;
  assign timeout_err = r_to;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_launch_nx = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SETUP;
      S_SETUP: if (r_set == c_settle_last) w_next = S_FIRE;
      S_FIRE:  w_next = S_WAIT;
      S_WAIT: begin
        if (r_done_s2)               w_next = S_EVAL;
        else if (r_wait == c_timeout) w_next = S_DONE;
      end
      S_EVAL: begin
        if (w_bit_done && (r_idx == c_last_idx)) w_next = S_DONE;
        else                                     w_next = S_SETUP;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // launch/arb_rst are registered from the next state so they are glitch-free and exclusive
    w_launch_nx = (w_next == S_FIRE) || (w_next == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_launch  <= 1'b0;
      r_arb_rst <= 1'b1;
      r_done_s1 <= 1'b0;
      r_done_s2 <= 1'b0;
      r_res_s1  <= 1'b0;
      r_res_s2  <= 1'b0;
      r_chal    <= '0;
      r_idx     <= '0;
      r_votes   <= '0;
      r_ones    <= '0;
      r_wait    <= '0;
      r_set     <= '0;
      r_resp    <= '0;
      r_to      <= 1'b0;
    end else begin
      r_launch  <= w_launch_nx;
      r_arb_rst <= ~w_launch_nx;
      r_done_s1 <= arb_done;
      r_done_s2 <= r_done_s1;
      r_res_s1  <= arb_result;
      r_res_s2  <= r_res_s1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chal  <= challenge;
            r_idx   <= '0;
            r_votes <= '0;
            r_ones  <= '0;
            r_resp  <= '0;
            r_to    <= 1'b0;
            r_set   <= '0;
          end
        end
        S_SETUP: r_set  <= r_set + 1'b1;
        S_FIRE:  r_wait <= '0;
        S_WAIT: begin
          if (r_done_s2) begin
            r_ones  <= r_ones + c_vote_w'(r_res_s2);
            r_votes <= r_votes + 1'b1;
          end else if (r_wait == c_timeout) begin
            r_to   <= 1'b1;
            r_resp <= '0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_EVAL: begin
          r_set <= '0;
          if (w_bit_done) begin
            for (int k = 0; k < NUM_RESP; k++) begin
              if (r_idx == c_idx_w'(k)) r_resp[k] <= w_maj;
            end
            r_votes <= '0;
            r_ones  <= '0;
            r_idx   <= r_idx + 1'b1;
            // stepping one bit per response bit gives chal_out = challenge rotated left by i
            r_chal  <= {r_chal[CHAL_W-2:0], r_chal[CHAL_W-1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/race_launcher.md
RACE_LAUNCHER -- requirements
Module: race_launcher

Interface
REQ-001 SHALL have parameter CHAL_W, default 64: challenge width, one bit per delay stage.
REQ-002 SHALL have parameter NUM_RESP, default 8: response bits produced per start.
REQ-003 SHALL have parameter VOTES, default 5: races per response bit; odd, 1..15.
REQ-004 SHALL have parameter SETTLE, default 4: cycles the arbiter is held in reset before each race; at least 1.
REQ-005 SHALL have parameter TIMEOUT, default 255: maximum wait cycles for arb_done per race.
REQ-006 SHALL have ports clk (input, 1): single clock, rising edge; all state is in this domain.
REQ-007 SHALL have port rst_n (input, 1): asynchronous active-low reset.
REQ-008 SHALL have port start (input, 1): request a response; accepted only when busy=0.
REQ-009 SHALL have port challenge (input, CHAL_W): sampled on the accepted start.
REQ-010 SHALL have port chal_out (output, CHAL_W): stage-select bits to the delay lines.
REQ-011 SHALL have port launch (output, 1): race edge driven into both delay-line inputs.
REQ-012 SHALL have port arb_rst (output, 1): active-high reset to the arbiter.
REQ-013 SHALL have port arb_done (input, 1): arbiter decision flag; asynchronous to clk.
REQ-014 SHALL have port arb_result (input, 1): arbiter winner bit; asynchronous to clk.
REQ-015 SHALL have port busy (output, 1): high from the accepted start through the resp_valid cycle.
REQ-016 SHALL have port resp_valid (output, 1): one-cycle pulse with the final response.
REQ-017 SHALL have port response (output, NUM_RESP): majority-voted response.
REQ-018 SHALL have port timeout_err (output, 1): set if any race timed out.

Function
REQ-019 SHALL pass arb_done and arb_result through two-flop synchronizers before any use; decisions SHALL use only the synchronized values.
REQ-020 SHALL implement states IDLE, SETUP, FIRE, WAIT, EVAL, DONE.
REQ-021 IDLE: busy=0, launch=0, arb_rst=1; start=1 -> latch challenge, clear bit index i, vote count v, ones count and response, clear timeout_err -> SETUP.
REQ-022 SETUP: arb_rst=1, launch=0, chal_out = latched challenge rotated left by i; stays exactly SETTLE cycles -> FIRE.
REQ-023 FIRE: arb_rst=0, launch=1 for one cycle, clear wait counter -> WAIT; chal_out stable from SETUP through WAIT.
REQ-024 WAIT: arb_rst=0, launch=1; synced done=1 -> add synced result to ones, v++ -> EVAL.
REQ-025 WAIT timeout: wait counter reaching TIMEOUT without synced done -> set timeout_err, force response=0 -> DONE.
REQ-026 EVAL, one cycle, launch=0, arb_rst=1: if v<VOTES -> SETUP; else response[i] = (ones > VOTES/2), clear v and ones, i++; i==NUM_RESP -> DONE, else -> SETUP.
REQ-027 DONE: resp_valid=1 for exactly one cycle, response and timeout_err valid -> IDLE; response and timeout_err hold until the next accepted start.
REQ-028 start while busy=1 SHALL be ignored, with no effect on state or latched challenge.
REQ-029 Counter widths SHALL hold VOTES, NUM_RESP and TIMEOUT without wrap; i SHALL never exceed NUM_RESP.
REQ-030 launch SHALL be a registered output, glitch-free, never high while arb_rst=1.
REQ-031 Minimum races per start SHALL be NUM_RESP*VOTES; per-race cycles = SETTLE + 1 + wait + 1.

Reset
REQ-032 rst_n=0 at any time, including mid-race, SHALL immediately force IDLE with: busy=0, launch=0, arb_rst=1, resp_valid=0, response=0, timeout_err=0, chal_out=0, synchronizers and all counters 0.
REQ-033 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising clk edge.

Verification
REQ-034 Defaults; arbiter model asserts done/result=1 three cycles after launch -> resp_valid after 40 races, response=8'hFF, timeout_err=0.
REQ-035 VOTES=5; model result pattern 1,0,1,0,1 per bit -> each bit 1; pattern 0,1,0,1,0 -> each bit 0; response matches the per-bit vote.
REQ-036 Model never asserts done -> timeout_err=1, response=0, and resp_valid exactly TIMEOUT+SETTLE+3 cycles after start.
REQ-037 start pulsed again during busy, with a different challenge -> ignored; chal_out sequence is the first challenge rotated left by 0..7.
REQ-038 rst_n low mid-WAIT -> all REQ-032 reset values the same cycle; next start completes normally.
REQ-039 Check every cycle: launch never high while arb_rst=1; resp_valid is a single-cycle pulse.
